// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and load writeback.
// Defining REGARB_CLEAR_EN adds a sequencer that writes zero to every register.
module regfile_write_arbiter #(
   parameter int unsigned width     = 16,
   parameter int unsigned addr_bits = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [addr_bits-1:0] req0_addr,
   input  logic [width-1:0]     req0_data,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [addr_bits-1:0] req1_addr,
   input  logic [width-1:0]     req1_data,
   input  logic                 clear_start,
   output logic                 clear_busy,
   output logic                 clear_done,
   output logic                 wr_en,
   output logic [addr_bits-1:0] wr_addr,
   output logic [width-1:0]     wr_data
);

   // Index of the requester granted most recently; 1 after reset so requester 0 wins first.
   logic last_grant;
   logic arb_en;

`ifdef REGARB_CLEAR_EN
   typedef enum logic {StIdle, StClear} state_t;

   localparam logic [addr_bits-1:0] CntOne = 1;

   state_t               state;
   logic [addr_bits-1:0] counter;
   // Set once the last address has been written; the following cycle exits the sequence.
   logic                 clear_wrap;

   assign arb_en = (state == StIdle) && !clear_start;
`else
   logic unused_clear_start;

   assign unused_clear_start = clear_start;
   assign arb_en             = 1'b1;
   assign clear_busy         = 1'b0;
   assign clear_done         = 1'b0;
`endif

   always_comb begin
      req0_ready = arb_en && req0_valid && (!req1_valid || last_grant);
      req1_ready = arb_en && req1_valid && (!req0_valid || !last_grant);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         last_grant <= 1'b1;
`ifdef REGARB_CLEAR_EN
         state      <= StIdle;
         counter    <= '0;
         clear_wrap <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (req0_ready) begin
            wr_en      <= 1'b1;
            wr_addr    <= req0_addr;
            wr_data    <= req0_data;
            last_grant <= 1'b0;
         end else if (req1_ready) begin
            wr_en      <= 1'b1;
            wr_addr    <= req1_addr;
            wr_data    <= req1_data;
            last_grant <= 1'b1;
         end
`ifdef REGARB_CLEAR_EN
         clear_done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (clear_start) begin
                  state      <= StClear;
                  counter    <= '0;
                  clear_wrap <= 1'b0;
               end
            end
            StClear: begin
               if (clear_wrap) begin
                  state      <= StIdle;
                  clear_wrap <= 1'b0;
                  clear_busy <= 1'b0;
                  clear_done <= 1'b1;
               end else begin
                  wr_en      <= 1'b1;
                  wr_addr    <= counter;
                  wr_data    <= '0;
                  clear_busy <= 1'b1;
                  counter    <= counter + CntOne;
                  if (counter == '1) clear_wrap <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; clear-sequencer cases follow REGARB_CLEAR_EN.
module tb_regfile_write_arbiter;
   localparam int unsigned Width = 16;
   localparam int unsigned AddrBits = 3;

   logic                clock = 1'b0;
   logic                reset;
   logic                req0_valid, req0_ready, req1_valid, req1_ready;
   logic [AddrBits-1:0] req0_addr, req1_addr;
   logic [Width-1:0]    req0_data, req1_data;
   logic                clear_start, clear_busy, clear_done;
   logic                wr_en;
   logic [AddrBits-1:0] wr_addr;
   logic [Width-1:0]    wr_data;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_write_arbiter #(.width(Width), .addr_bits(AddrBits)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; clear_start = 0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   initial begin
      int writes, dones;
      idle_inputs();
      reset = 1;
      #2;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", clear_busy, 0);
      check("rst_done", clear_done, 0);
      step();
      reset = 0;

      // Single requester
      req0_valid = 1; req0_addr = 3; req0_data = 16'h1234;
      #1;
      check("single_r0_ready", req0_ready, 1);
      check("single_r1_ready", req1_ready, 0);
      step();
      req0_valid = 0;
      check("single_wr_en", wr_en, 1);
      check("single_wr_addr", wr_addr, 3);
      check("single_wr_data", wr_data, 16'h1234);
      step();
      check("idle_wr_en", wr_en, 0);
      check("idle_wr_addr_hold", wr_addr, 3);

      // Contention alternates 0,1,0,1
      apply_reset();
      req0_valid = 1; req0_addr = 1; req0_data = 16'haaaa;
      req1_valid = 1; req1_addr = 2; req1_data = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_r0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
         check("rr_r1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
         step();
         check("rr_wr_addr", wr_addr, (i % 2 == 0) ? 1 : 2);
         check("rr_wr_data", wr_data, (i % 2 == 0) ? 16'haaaa : 16'h5555);
      end
      idle_inputs();

      // req1 alone twice, then contention goes to req0
      apply_reset();
      req1_valid = 1; req1_addr = 6; req1_data = 16'h0bee;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("solo1_ready", req1_ready, 1);
         step();
         check("solo1_wr_addr", wr_addr, 6);
      end
      req0_valid = 1; req0_addr = 1; req0_data = 16'h0c0c;
      #1;
      check("cont_r0_ready", req0_ready, 1);
      check("cont_r1_ready", req1_ready, 0);
      step();
      check("cont_wr_addr", wr_addr, 1);
      #1;
      check("cont_next_r1", req1_ready, 1);
      idle_inputs();

`ifdef REGARB_CLEAR_EN
      // Clear sequence beats a pending request
      apply_reset();
      req0_valid = 1; req0_addr = 5; req0_data = 16'hbeef;
      clear_start = 1;
      #1;
      check("clr_start_r0_ready", req0_ready, 0);
      step();
      clear_start = 0;
      check("clr_entry_busy", clear_busy, 0);
      check("clr_entry_wr_en", wr_en, 0);
      check("clr_entry_ready", req0_ready, 0);
      for (int k = 0; k < 8; k++) begin
         step();
         check("clr_wr_en", wr_en, 1);
         check("clr_wr_addr", wr_addr, k);
         check("clr_wr_data", wr_data, 0);
         check("clr_busy", clear_busy, 1);
         check("clr_done_early", clear_done, 0);
         check("clr_ready_low", req0_ready, 0);
      end
      step();
      check("clr_done", clear_done, 1);
      check("clr_busy_end", clear_busy, 0);
      check("clr_wr_en_end", wr_en, 0);
      check("clr_after_ready", req0_ready, 1);
      step();
      check("clr_after_wr_en", wr_en, 1);
      check("clr_after_wr_addr", wr_addr, 5);
      check("clr_after_done", clear_done, 0);
      idle_inputs();

      // Reset during the write to address 4 aborts without clear_done
      apply_reset();
      clear_start = 1;
      step();
      clear_start = 0;
      for (int k = 0; k < 5; k++) step();
      check("abort_pre_addr", wr_addr, 4);
      reset = 1;
      #1;
      check("abort_wr_en", wr_en, 0);
      check("abort_busy", clear_busy, 0);
      step();
      reset = 0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (clear_done) dones++;
      end
      check("abort_no_done", dones, 0);

      // Re-triggering mid-sequence does not extend it
      apply_reset();
      clear_start = 1;
      step();
      clear_start = 0;
      writes = 0; dones = 0;
      for (int k = 0; k < 16; k++) begin
         clear_start = (k == 3);
         step();
         if (wr_en) writes++;
         if (clear_done) dones++;
      end
      clear_start = 0;
      check("retrig_writes", writes, 8);
      check("retrig_dones", dones, 1);
`else
      // Without the sequencer clear_start is ignored
      apply_reset();
      req0_valid = 1; req0_addr = 2; req0_data = 16'h7777;
      clear_start = 1;
      #1;
      check("noclr_r0_ready", req0_ready, 1);
      step();
      clear_start = 0; req0_valid = 0;
      check("noclr_busy", clear_busy, 0);
      check("noclr_done", clear_done, 0);
      check("noclr_wr_en", wr_en, 1);
      check("noclr_wr_addr", wr_addr, 2);
      step();
      check("noclr_done_later", clear_done, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Mutual exclusion and ready-implies-valid on every cycle
   always @(negedge clock) begin
      if (!reset) begin
         if (req0_ready && req1_ready) check("both_ready", 1, 0);
         if (req0_ready && !req0_valid) check("r0_ready_no_valid", 1, 0);
         if (req1_ready && !req1_valid) check("r1_ready_no_valid", 1, 0);
      end
   end

endmodule
